// File: rtl/vga_sync_gen.sv
// vga_sync_gen: horizontal/vertical VGA timing generator, one count per pixel clock.
// Produces active-low hsync/vsync, video_on, pixel coordinates and line/frame
// start pulses. All decoded outputs are registered from the next-state counter
// values, so they stay cycle-aligned with pixel_x/pixel_y.
// Optional build macro VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame_count output.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]       frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_h_wrap;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_video_on_nxt;
  logic             w_line_start_nxt;
  logic             w_frame_start_nxt;

  // Next-state counters and the decode of those next-state values.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_MAX);
    w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + CNT_ONE;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = (r_v_cnt == V_MAX) ? '0 : r_v_cnt + CNT_ONE;
    end
    w_hsync_nxt       = !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
    w_vsync_nxt       = !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
    w_video_on_nxt    = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
    w_line_start_nxt  = (w_h_nxt == '0);
    w_frame_start_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
  end

  // Counter and decoded-output registers; reset parks at the last pixel of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= H_MAX;
      r_v_cnt       <= V_MAX;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_on_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_h_cnt;
  assign pixel_y     = r_v_cnt;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  // Frame counter advances on the same edge that registers frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= '0;
    end else if (w_frame_start_nxt) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule
